// File: rtl/button_debounce_pulse_pkg.sv
// Shared types and defaults for the pushbutton debounce front end.
// Optional build macro: DEBOUNCE_RELEASE_PULSE_EN (consumed by the interface and top).
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        HELD      = 2'd2,
        DISARMING = 2'd3
    } deb_state_e;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 1000000;

    // Stability counter width; a 1-bit counter is the floor.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce_pulse_if.sv
// Button-side signal bundle for button_debounce_pulse.
// btn_release exists only when DEBOUNCE_RELEASE_PULSE_EN is defined.
interface button_debounce_pulse_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic btn_release;

    modport master (output btn_in, input btn_level, input btn_press, input btn_release);
    modport slave  (input btn_in, output btn_level, output btn_press, output btn_release);
`else
    modport master (output btn_in, input btn_level, input btn_press);
    modport slave  (input btn_in, output btn_level, output btn_press);
`endif
endinterface

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Two-flop synchronizer with synchronous active-high reset; reused by other input stages.
// Unaffected by DEBOUNCE_RELEASE_PULSE_EN.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sync_out = s2_q;
endmodule

// File: rtl/button_debounce_pulse.sv
// Pushbutton debouncer: 2-flop sync, saturating stability counter, 4-state FSM.
// Define DEBOUNCE_RELEASE_PULSE_EN to add the btn_release pulse output.
//
//   state     | meaning
//   ----------+----------------------------------------------------
//   IDLE      | level 0, waiting for synced input to go high
//   ARMING    | input high, counting toward acceptance of a press
//   HELD      | level 1, waiting for synced input to go low
//   DISARMING | input low, counting toward acceptance of a release
module button_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    button_debounce_pulse_if.slave  bus
);
    localparam int unsigned     CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             btn_sync;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    logic             release_q, release_d;
`endif

    sync_2ff u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus.btn_in),
        .sync_out (btn_sync)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        release_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = ARMING;
                    cnt_d   = '0;
                end
            end
            ARMING: begin
                // A drop back to 0 is a bounce: restart from the stable low state.
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d = DISARMING;
                    cnt_d   = '0;
                end
            end
            DISARMING: begin
                if (btn_sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
                    release_d = 1'b1;
`endif
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            release_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
            release_q <= release_d;
`endif
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    assign bus.btn_release = release_q;
`endif
endmodule
